// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the multi-cycle execution sequencer: the sequencer
// state encoding, the word-access memory op code used for instruction fetch,
// and the default number of cycles a request or wait phase may last before
// the sequencer gives up.
// Ports: none (package only).
package core_pkg;

    // Sequencer phases. WB is the only phase that commits architectural state.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        EX      = 3'd3,
        LS_REQ  = 3'd4,
        LS_WAIT = 3'd5,
        WB      = 3'd6,
        ERR     = 3'd7
    } seq_state_e;

    localparam logic [2:0] MEM_OP_WORD = 3'b010;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/seq_timeout_cnt.sv
// seq_timeout_cnt
// Watchdog for one request or wait phase of the sequencer. The count is
// cleared whenever the sequencer is outside a counting phase or completes a
// handshake, and advances once per cycle spent in a counting phase. The
// expire flag marks the cycle in which the count would reach TIMEOUT.
// Ports:
//   clk_i     core clock
//   rst_ni    asynchronous active-low reset
//   clear_i   restart the count from zero on the next edge
//   en_i      sequencer is in a request or wait phase
//   expire_o  this cycle is the last one allowed in the current phase
module seq_timeout_cnt
    import core_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear has priority so a phase change always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count equals the number of cycles already spent in the phase, so
    // TIMEOUT-1 marks the TIMEOUT-th cycle.
    assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl
// Multi-cycle execution sequencer for the RV32 core. Walks every instruction
// through fetch, execute, optional load/store and write-back over a single
// valid/ready memory port, latches the fetched instruction and load data,
// and emits one-cycle commit strobes for the PC register and register file.
// Ports:
//   clk_i, rst_ni          core clock, asynchronous active-low reset
//   run_i                  keep issuing instructions while high
//   pc_i                   current PC from the PC register
//   alu_result_i           load/store address
//   mem_wr_i, mem_to_reg_i decoded store / load
//   mem_op_i, wdata_i      access size/sign and store data
//   mem_req_*              request channel (valid/ready handshake)
//   mem_resp_valid_i/data  read data or store acknowledge
//   inst_o, load_data_o    latched instruction and load result
//   pc_wen_o, reg_wen_o    commit strobes, high only in write-back
//   busy_o                 not idle
//   err_o                  sticky timeout flag
module exec_seq_ctrl
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic              mem_wr_i,
    input  logic              mem_to_reg_i,
    input  logic [2:0]        mem_op_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic              mem_req_wen_o,
    output logic [2:0]        mem_req_op_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              pc_wen_o,
    output logic              reg_wen_o,
    output logic              busy_o,
    output logic              err_o
);

    seq_state_e        state_q;
    logic [DATA_W-1:0] inst_q;
    logic [DATA_W-1:0] loadData_q;
    logic [ADDR_W-1:0] lsAddr_q;
    logic              lsWen_q;
    logic [2:0]        lsOp_q;
    logic [DATA_W-1:0] lsWdata_q;
    logic              lsIsLoad_q;

    logic reqState;
    logic waitState;
    logic hsDone;
    logic cntClear;
    logic expire;

    assign reqState  = (state_q == IF_REQ) || (state_q == LS_REQ);
    assign waitState = (state_q == IF_WAIT) || (state_q == LS_WAIT);

    // A completed handshake or response leaves the current phase, so the
    // watchdog restarts for the next phase.
    assign hsDone   = (reqState && mem_req_ready_i) || (waitState && mem_resp_valid_i);
    assign cntClear = !(reqState || waitState) || hsDone;

    seq_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cntClear),
        .en_i     (reqState || waitState),
        .expire_o (expire)
    );

    // Sequencer state and latches. The load/store request fields are captured
    // in EX, where decode and ALU outputs have settled, and then held for the
    // whole request phase. A handshake in the final allowed cycle still counts
    // as success; only a phase that runs out of cycles drops into ERR.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            inst_q     <= '0;
            loadData_q <= '0;
            lsAddr_q   <= '0;
            lsWen_q    <= 1'b0;
            lsOp_q     <= '0;
            lsWdata_q  <= '0;
            lsIsLoad_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_i) begin
                        state_q <= IF_REQ;
                    end
                end
                IF_REQ: begin
                    if (mem_req_ready_i) begin
                        state_q <= IF_WAIT;
                    end else if (expire) begin
                        state_q <= ERR;
                    end
                end
                IF_WAIT: begin
                    if (mem_resp_valid_i) begin
                        inst_q  <= mem_resp_data_i;
                        state_q <= EX;
                    end else if (expire) begin
                        state_q <= ERR;
                    end
                end
                EX: begin
                    if (mem_wr_i || mem_to_reg_i) begin
                        lsAddr_q   <= alu_result_i;
                        lsWen_q    <= mem_wr_i;
                        lsOp_q     <= mem_op_i;
                        lsWdata_q  <= wdata_i;
                        lsIsLoad_q <= mem_to_reg_i && !mem_wr_i;
                        state_q    <= LS_REQ;
                    end else begin
                        state_q <= WB;
                    end
                end
                LS_REQ: begin
                    if (mem_req_ready_i) begin
                        state_q <= LS_WAIT;
                    end else if (expire) begin
                        state_q <= ERR;
                    end
                end
                LS_WAIT: begin
                    if (mem_resp_valid_i) begin
                        if (lsIsLoad_q) begin
                            loadData_q <= mem_resp_data_i;
                        end
                        state_q <= WB;
                    end else if (expire) begin
                        state_q <= ERR;
                    end
                end
                WB: begin
                    state_q <= run_i ? IF_REQ : IDLE;
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Request outputs decode from state so reset removes them immediately.
    // The fetch address follows pc_i directly: the PC register is written at
    // the end of WB, so in the first fetch cycle only its output already holds
    // the new PC, and it cannot change again before the next WB.
    assign mem_req_valid_o = reqState;
    assign mem_req_addr_o  = (state_q == IF_REQ) ? pc_i :
                             (state_q == LS_REQ) ? lsAddr_q : '0;
    assign mem_req_wen_o   = (state_q == LS_REQ) && lsWen_q;
    assign mem_req_op_o    = (state_q == IF_REQ) ? MEM_OP_WORD :
                             (state_q == LS_REQ) ? lsOp_q : 3'b000;
    assign mem_req_wdata_o = (state_q == LS_REQ) ? lsWdata_q : '0;

    assign inst_o      = inst_q;
    assign load_data_o = loadData_q;
    assign pc_wen_o    = (state_q == WB);
    assign reg_wen_o   = (state_q == WB);
    assign busy_o      = (state_q != IDLE);
    assign err_o       = (state_q == ERR);

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// tb_exec_seq_ctrl
// Directed bench for exec_seq_ctrl. The bench plays the memory: every
// request it expects is pushed to a scoreboard queue before the instruction
// is started and popped when the DUT presents that request.
module tb_exec_seq_ctrl;
    import core_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [2:0]  op;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        rst_ni;
    logic        run;
    logic [31:0] pc;
    logic [31:0] aluResult;
    logic        memWr;
    logic        memToReg;
    logic [2:0]  memOp;
    logic [31:0] wdata;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqWen;
    logic [2:0]  reqOp;
    logic [31:0] reqWdata;
    logic        respValid;
    logic [31:0] respData;
    logic [31:0] inst;
    logic [31:0] loadData;
    logic        pcWen;
    logic        regWen;
    logic        busy;
    logic        err;

    int   errors = 0;
    int   checks = 0;
    req_t sb[$];

    exec_seq_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .run_i            (run),
        .pc_i             (pc),
        .alu_result_i     (aluResult),
        .mem_wr_i         (memWr),
        .mem_to_reg_i     (memToReg),
        .mem_op_i         (memOp),
        .wdata_i          (wdata),
        .mem_req_valid_o  (reqValid),
        .mem_req_ready_i  (reqReady),
        .mem_req_addr_o   (reqAddr),
        .mem_req_wen_o    (reqWen),
        .mem_req_op_o     (reqOp),
        .mem_req_wdata_o  (reqWdata),
        .mem_resp_valid_i (respValid),
        .mem_resp_data_i  (respData),
        .inst_o           (inst),
        .load_data_o      (loadData),
        .pc_wen_o         (pcWen),
        .reg_wen_o        (regWen),
        .busy_o           (busy),
        .err_o            (err)
    );

    // Free-running clock; the bench samples and drives on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Serve one request: compare it with the scoreboard head, hold ready low
    // for 'stall' cycles while checking the fields stay put, complete the
    // handshake, then return the response one cycle later.
    task automatic applyStimulus(input int stall, input logic [31:0] rdata,
                                 input bit dropRun);
        req_t exp;
        int   waitCycles = 0;
        while (!reqValid && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("reqValid", {31'd0, reqValid}, 32'd1);
        if (sb.size() == 0) begin
            $display("[TB] FAIL sbEmpty observed=0 expected=1");
            $fatal(1, "[TB] scoreboard underflow");
        end
        exp = sb.pop_front();
        checkOutput("reqAddr", reqAddr, exp.addr);
        checkOutput("reqWen", {31'd0, reqWen}, {31'd0, exp.wen});
        checkOutput("reqOp", {29'd0, reqOp}, {29'd0, exp.op});
        checkOutput("reqWdata", reqWdata, exp.wdata);
        for (int i = 0; i < stall; i++) begin
            reqReady = 1'b0;
            @(negedge clk);
            checkOutput("stallValid", {31'd0, reqValid}, 32'd1);
            checkOutput("stallAddr", reqAddr, exp.addr);
            checkOutput("stallWdata", reqWdata, exp.wdata);
        end
        reqReady = 1'b1;
        @(negedge clk);
        reqReady = 1'b0;
        checkOutput("waitValid", {31'd0, reqValid}, 32'd0);
        respValid = 1'b1;
        respData  = rdata;
        if (dropRun) begin
            run = 1'b0;
        end
        @(negedge clk);
        respValid = 1'b0;
        respData  = '0;
    endtask

    initial begin
        int validCycles;

        rst_ni    = 1'b0;
        run       = 1'b0;
        pc        = '0;
        aluResult = '0;
        memWr     = 1'b0;
        memToReg  = 1'b0;
        memOp     = 3'b000;
        wdata     = '0;
        reqReady  = 1'b0;
        respValid = 1'b0;
        respData  = '0;

        // Reset state
        @(negedge clk);
        checkOutput("rstValid", {31'd0, reqValid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstErr", {31'd0, err}, 32'd0);
        checkOutput("rstInst", inst, 32'd0);
        checkOutput("rstLoad", loadData, 32'd0);
        checkOutput("rstPcWen", {31'd0, pcWen}, 32'd0);
        checkOutput("rstAddr", reqAddr, 32'd0);
        rst_ni = 1'b1;

        // ALU op: fetch, EX, WB in cycle 4
        pc  = 32'h8000_0000;
        run = 1'b1;
        sb.push_back('{addr: 32'h8000_0000, wen: 1'b0, op: MEM_OP_WORD, wdata: 32'd0});
        @(negedge clk);
        applyStimulus(0, 32'h0010_0093, 1'b0);
        checkOutput("aluInst", inst, 32'h0010_0093);
        checkOutput("aluExPcWen", {31'd0, pcWen}, 32'd0);
        checkOutput("aluExBusy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("aluWbPcWen", {31'd0, pcWen}, 32'd1);
        checkOutput("aluWbRegWen", {31'd0, regWen}, 32'd1);
        checkOutput("aluWbValid", {31'd0, reqValid}, 32'd0);

        // Load: next fetch right after WB, LS request with wen=0, WB in cycle 6
        pc        = 32'h8000_0004;
        memToReg  = 1'b1;
        aluResult = 32'h8000_1000;
        memOp     = 3'b010;
        wdata     = 32'h1111_1111;
        sb.push_back('{addr: 32'h8000_0004, wen: 1'b0, op: MEM_OP_WORD, wdata: 32'd0});
        sb.push_back('{addr: 32'h8000_1000, wen: 1'b0, op: 3'b010, wdata: 32'h1111_1111});
        @(negedge clk);
        checkOutput("b2bValid", {31'd0, reqValid}, 32'd1);
        applyStimulus(0, 32'h0000_2083, 1'b0);
        checkOutput("ldInst", inst, 32'h0000_2083);
        @(negedge clk);
        applyStimulus(0, 32'hDEAD_BEEF, 1'b0);
        checkOutput("ldData", loadData, 32'hDEAD_BEEF);
        checkOutput("ldWbPcWen", {31'd0, pcWen}, 32'd1);

        // Store under backpressure: ready low for 3 cycles, load data untouched
        pc        = 32'h8000_0008;
        memToReg  = 1'b0;
        memWr     = 1'b1;
        aluResult = 32'h8000_2000;
        memOp     = 3'b001;
        wdata     = 32'hCAFE_F00D;
        sb.push_back('{addr: 32'h8000_0008, wen: 1'b0, op: MEM_OP_WORD, wdata: 32'd0});
        sb.push_back('{addr: 32'h8000_2000, wen: 1'b1, op: 3'b001, wdata: 32'hCAFE_F00D});
        @(negedge clk);
        applyStimulus(0, 32'h0011_2023, 1'b0);
        @(negedge clk);
        applyStimulus(3, 32'h1234_5678, 1'b0);
        checkOutput("stLoadKept", loadData, 32'hDEAD_BEEF);
        checkOutput("stWbPcWen", {31'd0, pcWen}, 32'd1);

        // Run dropped during LS_WAIT: completes through WB, then IDLE
        pc        = 32'h8000_000C;
        memWr     = 1'b0;
        memToReg  = 1'b1;
        aluResult = 32'h8000_3000;
        memOp     = 3'b100;
        wdata     = 32'h0;
        sb.push_back('{addr: 32'h8000_000C, wen: 1'b0, op: MEM_OP_WORD, wdata: 32'd0});
        sb.push_back('{addr: 32'h8000_3000, wen: 1'b0, op: 3'b100, wdata: 32'd0});
        @(negedge clk);
        applyStimulus(0, 32'h0000_4083, 1'b0);
        @(negedge clk);
        applyStimulus(0, 32'h0BAD_F00D, 1'b1);
        checkOutput("dropWbPcWen", {31'd0, pcWen}, 32'd1);
        checkOutput("dropLoad", loadData, 32'h0BAD_F00D);
        @(negedge clk);
        checkOutput("dropIdleBusy", {31'd0, busy}, 32'd0);
        checkOutput("dropIdlePcWen", {31'd0, pcWen}, 32'd0);
        @(negedge clk);
        checkOutput("dropStayIdle", {31'd0, busy}, 32'd0);
        checkOutput("dropNoReq", {31'd0, reqValid}, 32'd0);

        // Asynchronous reset in IF_REQ, then a late response while idle
        memToReg = 1'b0;
        pc       = 32'h8000_0010;
        run      = 1'b1;
        @(negedge clk);
        checkOutput("arValidBefore", {31'd0, reqValid}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("arValidAsync", {31'd0, reqValid}, 32'd0);
        checkOutput("arBusyAsync", {31'd0, busy}, 32'd0);
        run = 1'b0;
        #1 rst_ni = 1'b1;
        @(negedge clk);
        respValid = 1'b1;
        respData  = 32'hFFFF_FFFF;
        @(negedge clk);
        respValid = 1'b0;
        respData  = '0;
        checkOutput("arLateInst", inst, 32'd0);
        checkOutput("arLateLoad", loadData, 32'd0);
        checkOutput("arLateBusy", {31'd0, busy}, 32'd0);

        // Timeout: ready stuck low, ERR after 255 request cycles
        pc  = 32'h8000_0020;
        run = 1'b1;
        @(negedge clk);
        validCycles = 0;
        while (reqValid && validCycles < 400) begin
            validCycles++;
            @(negedge clk);
        end
        checkOutput("toCycles", validCycles, 32'd255);
        checkOutput("toErr", {31'd0, err}, 32'd1);
        checkOutput("toValid", {31'd0, reqValid}, 32'd0);
        checkOutput("toBusy", {31'd0, busy}, 32'd1);
        run = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("toErrSticky", {31'd0, err}, 32'd1);
        checkOutput("toValidSticky", {31'd0, reqValid}, 32'd0);
        rst_ni = 1'b0;
        #1;
        checkOutput("toErrCleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        checkOutput("toIdleAfterRst", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_seq_ctrl.md
# exec_seq_ctrl

Multi-cycle execution sequencer for the RV32 core. It converts the single-cycle datapath into a fetch/execute/memory/write-back sequence over one shared memory port that uses a valid/ready handshake. It owns the instruction latch and the load-data latch. It generates the commit strobes that gate the PC register and register-file writes. It sits between the core datapath (IDU, ALU, PC logic) and the memory bus.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, instruction/data width
- `TIMEOUT`, 255, maximum cycles spent in one REQ or WAIT state before the block signals an error

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-low reset
- `run`  in  1  level; while high the block keeps issuing instructions
- `pc`  in  ADDR_W  current PC from the PC register
- `alu_result`  in  ADDR_W  load/store address
- `mem_wr`  in  1  decoded store
- `mem_to_reg`  in  1  decoded load
- `mem_op`  in  3  decoded access size/sign, passed through
- `wdata`  in  DATA_W  store data (rs2)
- `mem_req_valid`  out  1
- `mem_req_ready`  in  1
- `mem_req_addr`  out  ADDR_W
- `mem_req_wen`  out  1
- `mem_req_op`  out  3
- `mem_req_wdata`  out  DATA_W
- `mem_resp_valid`  in  1  read data valid, or store acknowledge
- `mem_resp_data`  in  DATA_W
- `inst`  out  DATA_W  latched instruction, drives IDU
- `load_data`  out  DATA_W  latched load result
- `pc_wen`  out  1  one-cycle commit strobe for the PC register
- `reg_wen`  out  1  one-cycle commit strobe, ANDed externally with RegWr
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky timeout flag

## Operation
States:
- **IDLE**: go to IF_REQ when `run`=1.
- **IF_REQ**: `mem_req_valid`=1, `addr`=`pc`, `wen`=0, `op`=3'b010 (word). On `ready` go to IF_WAIT.
- **IF_WAIT**: on `resp_valid`, latch `inst`←`resp_data` and go to EX.
- **EX**: one cycle so decode and ALU settle. If `mem_wr` or `mem_to_reg`, go to LS_REQ; otherwise go to WB.
- **LS_REQ**: `valid`=1, `addr`=`alu_result`, `wen`=`mem_wr`, `op`=`mem_op`, `wdata`=`wdata`. On `ready` go to LS_WAIT.
- **LS_WAIT**: on `resp_valid`, latch `load_data` (loads only; stores only await the ack) and go to WB.
- **WB**: `pc_wen`=1 and `reg_wen`=1 for exactly this cycle. Then go to IF_REQ if `run`, else IDLE.
- **ERR**: all request outputs are 0, `err`=1. ERR is left only by reset.

Request and response rules:
- Request fields are registered and held stable while `valid`=1 and `ready`=0. `valid` never drops before the handshake completes.
- `mem_resp_valid` is ignored outside the WAIT states. A response arrives no earlier than the cycle after the request handshake.
- Stores do not write `load_data`. `load_data` keeps its previous value.

Run, reset and timeout:
- Deasserting `run` mid-instruction does not abort. The current instruction completes through WB, then the block enters IDLE.
- Timeout counter: cleared on every state entry and increments each cycle spent in REQ or WAIT. Reaching `TIMEOUT` causes a transition to ERR instead of the normal next state. Its width is clog2(TIMEOUT+1).
- Reset values: state=IDLE, `inst`=0, `load_data`=0, counter=0, every output 0.
- Reset mid-transaction drops `mem_req_valid` asynchronously. An in-flight response after reset is ignored (the block is in IDLE).

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `mem_req_ready` or `mem_resp_valid` to any output.
- Minimum latency, with `ready`=1 in the first REQ cycle and the response one cycle later:
  - ALU/branch instruction: 4 cycles (IF_REQ, IF_WAIT, EX, WB).
  - Load/store: 6 cycles.
- Back-to-back: the IF_REQ for the next instruction is issued in the cycle after WB. `pc` is already updated at that point.
- `inst` is stable from the cycle after IF_WAIT until the next IF_WAIT handshake.

## Structure
- Shared package `core_pkg`:
  - state enum (IDLE, IF_REQ, IF_WAIT, EX, LS_REQ, LS_WAIT, WB, ERR)
  - `MEM_OP_WORD` = 3'b010
  - default `TIMEOUT`
- Sub-module `seq_timeout_cnt`: clear, enable and expire, parameterised by `TIMEOUT`.

## Test plan
- Fetch of an ALU op: `run`=1, `pc`=0x80000000, `ready`=1, response 0x00100093 one cycle later → `inst`=0x00100093, `pc_wen`/`reg_wen` pulse in cycle 4, next `mem_req_addr`=`pc` in cycle 5.
- Load: `mem_to_reg`=1, `alu_result`=0x80001000, response 0xDEADBEEF → LS request has `wen`=0 and `addr`=0x80001000; `load_data`=0xDEADBEEF; WB in cycle 6.
- Store under backpressure: `mem_wr`=1, `ready` held low 3 cycles → `valid` and `addr`/`wdata` held stable for 4 cycles; `load_data` unchanged; WB follows the ack.
- Timeout: `ready` stuck at 0 → ERR entered after 255 cycles, `err`=1, `valid`=0; stays in ERR until `rst`=0.
- `run` dropped during LS_WAIT → instruction completes, WB pulses once, then IDLE with `busy`=0.
- Async reset asserted in IF_REQ (mid-cycle) → `mem_req_valid` falls immediately; a late `resp_valid` after release causes no latch update.
